rect_fill_engine: RTL and testbench
===================================

Name: rect_fill_engine

Overview:
- Sequential rectangle rasteriser for the VRAM path.
- On a start command it latches centre, half-extents and colour, and clips the rectangle to the framebuffer.
- It then walks the clipped area row-major and issues one pixel write per accepted cycle to the VRAM write port.
- It generalises the combinational per-pixel rectangle test: framebuffer size, address, data and coordinate widths are parameters; a start/busy/done handshake, write backpressure and clipping are added.

Parameters:
- ADDR_WIDTH, 16, VRAM address width; must hold FB_WIDTH*FB_HEIGHT-1.
- DATA_WIDTH, 4, pixel colour width.
- COORD_WIDTH, 11, unsigned width of coordinate and half-extent inputs.
- FB_WIDTH, 200, framebuffer width in pixels; also the row stride.
- FB_HEIGHT, 150, framebuffer height in pixels.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset; synchronous, active-high.
- i_start  input  1  start request; sampled only in IDLE.
- i_ctr_x  input  COORD_WIDTH  rectangle centre x.
- i_ctr_y  input  COORD_WIDTH  rectangle centre y.
- i_half_width  input  COORD_WIDTH  half width.
- i_half_height  input  COORD_WIDTH  half height.
- i_color  input  DATA_WIDTH  fill colour.
- i_outline  input  1  outline-only request; ignored unless RECT_OUTLINE_EN is defined.
- i_ready  input  1  VRAM port accepts the write this cycle.
- o_busy  output  1  high from SETUP through DONE.
- o_done  output  1  one-cycle completion pulse.
- o_we  output  1  write valid.
- o_addr  output  ADDR_WIDTH  pixel address, y*FB_WIDTH+x.
- o_data  output  DATA_WIDTH  pixel colour.

Behaviour:
- Reset: rst is synchronous, active-high, and takes priority over everything, including mid-draw. It forces state IDLE and clears o_busy, o_done, o_we, o_addr, o_data and all internal registers. A partially drawn rectangle is abandoned.
- States: IDLE -> SETUP -> RUN -> DONE -> IDLE.
- IDLE: if i_start=1, latch all inputs and go to SETUP. i_start in any other state is ignored, not queued.
- SETUP (1 cycle):
  - Compute bounds in signed COORD_WIDTH+2 arithmetic: xl=ctr_x-hw, xh=ctr_x+hw (exclusive), yl=ctr_y-hh, yh=ctr_y+hh (exclusive).
  - Clip: x0=max(xl,0), x1=min(xh,FB_WIDTH), y0=max(yl,0), y1=min(yh,FB_HEIGHT).
  - If x0>=x1 or y0>=y1 (this includes hw=0 or hh=0), go to DONE with no writes.
  - Otherwise set x=x0, y=y0, row_base=y0*FB_WIDTH, and go to RUN.
- RUN:
  - o_we=1, o_addr=row_base+x (truncated to ADDR_WIDTH), o_data=latched colour.
  - A pixel is consumed when o_we && i_ready. While i_ready=0, o_we, o_addr and o_data hold stable.
  - On consume, x increments. At x=x1-1, x wraps to x0, y increments and row_base += FB_WIDTH (no multiplier in the loop).
  - Consuming the pixel at (x1-1, y1-1) goes to DONE.
- DONE (1 cycle): o_done=1, o_we=0, o_busy=1; the next state is IDLE.
- o_busy is 0 only in IDLE.
- Latency: the first o_we is 2 cycles after the i_start sample edge. With i_ready held high, N pixels finish with o_done at cycle N+2 after start.
- o_addr and o_data are registered outputs. Throughput is 1 pixel/cycle.

Optional Feature:
- Macro: RECT_OUTLINE_EN.
- Defined:
  - i_outline is latched at start.
  - If the latched value is 1, a pixel is written only if x==xl, x==xh-1, y==yl or y==yh-1. Edges use the unclipped bounds, so clipped-away edges are not drawn.
  - Interior pixels still occupy one RUN cycle each, with o_we=0, and advance regardless of i_ready.
- Not defined: i_outline is unused and every pixel is filled.

Test Plan:
- Basic fill: FB 200x150, ctr=(100,75), hw=2, hh=1, colour=4'hA, i_ready=1.
  - Exactly 8 writes at addresses 14898..14901 then 15098..15101, all with data A.
  - o_we high on cycles 2..9 after start; o_done on cycle 10.
- Clipping: ctr=(1,1), hw=3, hh=2.
  - 12 writes covering x 0..3, y 0..2.
  - First address 0, last address 403; no address wraps.
- Empty and ignored start:
  - hw=0: o_done on cycle 2 with no o_we.
  - i_start pulsed during RUN has no effect: write count unchanged and no second o_done.
- Backpressure: basic fill with i_ready=0 for 3 cycles while o_addr=14899.
  - o_addr=14899 and o_data=A held for those cycles.
  - Still 8 writes total; o_done delayed 3 cycles, to cycle 13.
- Reset mid-op: assert rst on the 4th write of the basic fill.
  - Next cycle: o_we=0, o_busy=0, o_done=0, o_addr=0.
  - A new start then draws all 8 pixels correctly.
- Outline (macro defined): ctr=(100,75), hw=2, hh=2, i_outline=1.
  - 16 RUN cycles with 12 writes.
  - Addresses 14899, 14900, 15099, 15100 are never written.

Source files
------------

// File: rtl/rect_fill_engine.sv
// Sequential rectangle rasteriser: clips a centred rectangle to the framebuffer and streams pixel writes.
// Define RECT_OUTLINE_EN to enable outline-only drawing through i_outline.
module rect_fill_engine #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 4,
    parameter int COORD_WIDTH = 11,
    parameter int FB_WIDTH    = 200,
    parameter int FB_HEIGHT   = 150
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [COORD_WIDTH-1:0] i_ctr_x,
    input  logic [COORD_WIDTH-1:0] i_ctr_y,
    input  logic [COORD_WIDTH-1:0] i_half_width,
    input  logic [COORD_WIDTH-1:0] i_half_height,
    input  logic [DATA_WIDTH-1:0]  i_color,
    input  logic                   i_outline,
    input  logic                   i_ready,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_we,
    output logic [ADDR_WIDTH-1:0]  o_addr,
    output logic [DATA_WIDTH-1:0]  o_data
);

    localparam int SW = COORD_WIDTH + 2;

    typedef logic signed [SW-1:0] coord_t;

    localparam coord_t                  FBW    = coord_t'(FB_WIDTH);
    localparam coord_t                  FBH    = coord_t'(FB_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0]   STRIDE = ADDR_WIDTH'(FB_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        RUN,
        DONE
    } state_t;

    state_t                 state;
    logic [COORD_WIDTH-1:0] ctr_x;
    logic [COORD_WIDTH-1:0] ctr_y;
    logic [COORD_WIDTH-1:0] half_w;
    logic [COORD_WIDTH-1:0] half_h;
    logic [DATA_WIDTH-1:0]  color;
    coord_t                 x;
    coord_t                 y;
    coord_t                 x0;
    coord_t                 x1;
    coord_t                 y1;
    logic [ADDR_WIDTH-1:0]  row_base;

`ifdef RECT_OUTLINE_EN
    logic   outline_q;
    coord_t exl;
    coord_t exh;
    coord_t eyl;
    coord_t eyh;
    coord_t bxl;
    coord_t bxh;
    coord_t byl;
    coord_t byh;
`else
    logic unused_outline;
    assign unused_outline = i_outline;
`endif

    coord_t                xl;
    coord_t                xh;
    coord_t                yl;
    coord_t                yh;
    coord_t                cx0;
    coord_t                cx1;
    coord_t                cy0;
    coord_t                cy1;
    logic                  empty;
    logic                  last_col;
    logic                  last_px;
    coord_t                nx;
    coord_t                ny;
    logic [ADDR_WIDTH-1:0] nrb;
    logic                  next_on;
    logic                  advance;

    // Bounds/clip from latched inputs, plus the coordinates of the pixel to present next.
    always_comb begin
        xl  = coord_t'({2'b00, ctr_x}) - coord_t'({2'b00, half_w});
        xh  = coord_t'({2'b00, ctr_x}) + coord_t'({2'b00, half_w});
        yl  = coord_t'({2'b00, ctr_y}) - coord_t'({2'b00, half_h});
        yh  = coord_t'({2'b00, ctr_y}) + coord_t'({2'b00, half_h});
        cx0 = xl[SW-1] ? '0 : xl;
        cy0 = yl[SW-1] ? '0 : yl;
        cx1 = (xh > FBW) ? FBW : xh;
        cy1 = (yh > FBH) ? FBH : yh;
        empty = (cx0 >= cx1) || (cy0 >= cy1);

        last_col = (x == x1 - coord_t'(1));
        last_px  = last_col && (y == y1 - coord_t'(1));

        if (state == SETUP) begin
            nx  = cx0;
            ny  = cy0;
            nrb = ADDR_WIDTH'(int'(cy0) * FB_WIDTH);
        end else begin
            nx  = last_col ? x0 : x + coord_t'(1);
            ny  = last_col ? y + coord_t'(1) : y;
            nrb = last_col ? row_base + STRIDE : row_base;
        end

`ifdef RECT_OUTLINE_EN
        bxl = (state == SETUP) ? xl : exl;
        bxh = (state == SETUP) ? xh : exh;
        byl = (state == SETUP) ? yl : eyl;
        byh = (state == SETUP) ? yh : eyh;
        next_on = !outline_q || (nx == bxl) || (nx == bxh - coord_t'(1)) ||
                  (ny == byl) || (ny == byh - coord_t'(1));
`else
        next_on = 1'b1;
`endif

        // Skipped interior pixels (o_we low) advance without waiting on the port.
        advance = !o_we || i_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ctr_x    <= '0;
            ctr_y    <= '0;
            half_w   <= '0;
            half_h   <= '0;
            color    <= '0;
            x        <= '0;
            y        <= '0;
            x0       <= '0;
            x1       <= '0;
            y1       <= '0;
            row_base <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_we     <= 1'b0;
            o_addr   <= '0;
            o_data   <= '0;
`ifdef RECT_OUTLINE_EN
            outline_q <= 1'b0;
            exl       <= '0;
            exh       <= '0;
            eyl       <= '0;
            eyh       <= '0;
`endif
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    o_we <= 1'b0;
                    if (i_start) begin
                        ctr_x  <= i_ctr_x;
                        ctr_y  <= i_ctr_y;
                        half_w <= i_half_width;
                        half_h <= i_half_height;
                        color  <= i_color;
`ifdef RECT_OUTLINE_EN
                        outline_q <= i_outline;
`endif
                        o_busy <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    x0 <= cx0;
                    x1 <= cx1;
                    y1 <= cy1;
`ifdef RECT_OUTLINE_EN
                    exl <= xl;
                    exh <= xh;
                    eyl <= yl;
                    eyh <= yh;
`endif
                    if (empty) begin
                        o_done <= 1'b1;
                        state  <= DONE;
                    end else begin
                        x        <= nx;
                        y        <= ny;
                        row_base <= nrb;
                        o_we     <= next_on;
                        o_addr   <= nrb + ADDR_WIDTH'(nx);
                        o_data   <= color;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (advance) begin
                        if (last_px) begin
                            o_we   <= 1'b0;
                            o_done <= 1'b1;
                            state  <= DONE;
                        end else begin
                            x        <= nx;
                            y        <= ny;
                            row_base <= nrb;
                            o_we     <= next_on;
                            o_addr   <= nrb + ADDR_WIDTH'(nx);
                        end
                    end
                end
                DONE: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed self-checking bench for rect_fill_engine (200x150 framebuffer, 4-bit colour).
module tb_rect_fill_engine;

    localparam int AW = 16;
    localparam int DW = 4;
    localparam int CW = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic [CW-1:0] i_ctr_x;
    logic [CW-1:0] i_ctr_y;
    logic [CW-1:0] i_half_width;
    logic [CW-1:0] i_half_height;
    logic [DW-1:0] i_color;
    logic          i_outline;
    logic          i_ready;
    logic          o_busy;
    logic          o_done;
    logic          o_we;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_data;

    rect_fill_engine #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .COORD_WIDTH(CW),
        .FB_WIDTH   (200),
        .FB_HEIGHT  (150)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_ctr_x      (i_ctr_x),
        .i_ctr_y      (i_ctr_y),
        .i_half_width (i_half_width),
        .i_half_height(i_half_height),
        .i_color      (i_color),
        .i_outline    (i_outline),
        .i_ready      (i_ready),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_we         (o_we),
        .o_addr       (o_addr),
        .o_data       (o_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int wr_addr[$];
    int wr_data[$];
    int first_we;
    int last_we;
    int done_cyc;
    int done_count;
    int stall_seen;
    int busy_at_done;
    int busy_after;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0d, expected %0d", tag, $signed(actual), $signed(expected));
        end
    endtask

    // Runs one rectangle from start to a few cycles past o_done; cycle 1 is the cycle after the start sample edge.
    task automatic applyStimulus(input int cx, input int cy, input int hw, input int hh, input int color,
                                 input int outline, input int stall_addr, input int stall_len,
                                 input int pulse_cyc);
        int stall_left;
        int cyc;
        int after;
        wr_addr.delete();
        wr_data.delete();
        first_we     = -1;
        last_we      = -1;
        done_cyc     = -1;
        done_count   = 0;
        stall_seen   = 0;
        busy_at_done = -1;
        busy_after   = -1;
        stall_left   = stall_len;
        i_ctr_x       = CW'(cx);
        i_ctr_y       = CW'(cy);
        i_half_width  = CW'(hw);
        i_half_height = CW'(hh);
        i_color       = DW'(color);
        i_outline     = outline[0];
        i_ready       = 1'b1;
        i_start       = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        cyc   = 1;
        after = 0;
        while (cyc < 300 && after < 5) begin
            i_start = (cyc == pulse_cyc);
            i_ready = 1'b1;
            if (o_we && stall_left > 0 && int'(o_addr) == stall_addr) begin
                i_ready = 1'b0;
                stall_left--;
                if (int'(o_data) == color) stall_seen++;
            end
            if (o_we && i_ready) begin
                wr_addr.push_back(int'(o_addr));
                wr_data.push_back(int'(o_data));
                if (first_we < 0) first_we = cyc;
                last_we = cyc;
            end
            if (o_done) begin
                done_count++;
                if (done_cyc < 0) begin
                    done_cyc     = cyc;
                    busy_at_done = int'(o_busy);
                end
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = int'(o_busy);
            if (done_cyc >= 0) after++;
            @(posedge clk);
            #1;
            cyc++;
        end
        i_start = 1'b0;
        i_ready = 1'b1;
    endtask

    // Compares the recorded writes against a row-major walk of x in [xa,xb], y in [ya,yb].
    task automatic checkWrites(input string tag, input int xa, input int xb, input int ya, input int yb,
                               input int color);
        int n;
        int bad_data;
        n = 0;
        bad_data = 0;
        checkOutput({tag, "_count"}, wr_addr.size(), (xb - xa + 1) * (yb - ya + 1));
        for (int yy = ya; yy <= yb; yy++) begin
            for (int xx = xa; xx <= xb; xx++) begin
                checkOutput({tag, "_addr"}, (n < wr_addr.size()) ? wr_addr[n] : -1, yy * 200 + xx);
                n++;
            end
        end
        foreach (wr_data[i]) if (wr_data[i] != color) bad_data++;
        checkOutput({tag, "_data"}, bad_data, 0);
    endtask

    initial begin
        int n;
        int hits;
        int wrote4;
        rst           = 1'b1;
        i_start       = 1'b0;
        i_ctr_x       = '0;
        i_ctr_y       = '0;
        i_half_width  = '0;
        i_half_height = '0;
        i_color       = '0;
        i_outline     = 1'b0;
        i_ready       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_busy", o_busy, 0);
        checkOutput("reset_we", o_we, 0);
        checkOutput("reset_done", o_done, 0);
        checkOutput("reset_addr", o_addr, 0);

        $display("[TB] basic fill");
        applyStimulus(100, 75, 2, 1, 'hA, 0, -1, 0, -1);
        checkWrites("basic", 98, 101, 74, 75, 'hA);
        checkOutput("basic_first_we", first_we, 2);
        checkOutput("basic_last_we", last_we, 9);
        checkOutput("basic_done_cyc", done_cyc, 10);
        checkOutput("basic_done_count", done_count, 1);
        checkOutput("basic_busy_done", busy_at_done, 1);
        checkOutput("basic_busy_after", busy_after, 0);

        $display("[TB] clipping");
        applyStimulus(1, 1, 3, 2, 'h5, 0, -1, 0, -1);
        checkWrites("clip", 0, 3, 0, 2, 'h5);
        checkOutput("clip_first", (wr_addr.size() > 0) ? wr_addr[0] : -1, 0);
        checkOutput("clip_last", (wr_addr.size() > 0) ? wr_addr[wr_addr.size()-1] : -1, 403);
        checkOutput("clip_done_cyc", done_cyc, 14);

        $display("[TB] empty rectangle");
        applyStimulus(100, 75, 0, 4, 'h3, 0, -1, 0, -1);
        checkOutput("empty_writes", wr_addr.size(), 0);
        checkOutput("empty_done_cyc", done_cyc, 2);
        checkOutput("empty_done_count", done_count, 1);

        $display("[TB] start during run");
        applyStimulus(100, 75, 2, 1, 'hA, 0, -1, 0, 5);
        checkOutput("restart_writes", wr_addr.size(), 8);
        checkOutput("restart_done_count", done_count, 1);
        checkOutput("restart_done_cyc", done_cyc, 10);

        $display("[TB] backpressure");
        applyStimulus(100, 75, 2, 1, 'hA, 0, 14899, 3, -1);
        checkWrites("stall", 98, 101, 74, 75, 'hA);
        checkOutput("stall_hold", stall_seen, 3);
        checkOutput("stall_done_cyc", done_cyc, 13);

        $display("[TB] reset mid-draw");
        i_ctr_x       = CW'(100);
        i_ctr_y       = CW'(75);
        i_half_width  = CW'(2);
        i_half_height = CW'(1);
        i_color       = DW'(4'hA);
        i_outline     = 1'b0;
        i_start       = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        n = 0;
        wrote4 = -1;
        for (int c = 0; c < 40 && wrote4 < 0; c++) begin
            if (o_we) n++;
            if (n == 4) wrote4 = int'(o_addr);
            else begin
                @(posedge clk);
                #1;
            end
        end
        checkOutput("rst_fourth_addr", wrote4, 14901);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_we", o_we, 0);
        checkOutput("rst_busy", o_busy, 0);
        checkOutput("rst_done", o_done, 0);
        checkOutput("rst_addr", o_addr, 0);
        applyStimulus(100, 75, 2, 1, 'hA, 0, -1, 0, -1);
        checkWrites("after_rst", 98, 101, 74, 75, 'hA);
        checkOutput("after_rst_done_cyc", done_cyc, 10);

        $display("[TB] outline request");
        applyStimulus(100, 75, 2, 2, 'h7, 1, -1, 0, -1);
        hits = 0;
        foreach (wr_addr[i])
            if (wr_addr[i] == 14899 || wr_addr[i] == 14900 || wr_addr[i] == 15099 || wr_addr[i] == 15100)
                hits++;
        checkOutput("outline_done_cyc", done_cyc, 18);
`ifdef RECT_OUTLINE_EN
        checkOutput("outline_writes", wr_addr.size(), 12);
        checkOutput("outline_interior", hits, 0);
`else
        checkOutput("outline_writes", wr_addr.size(), 16);
        checkOutput("outline_interior", hits, 4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
